// File: rtl/mips_multicycle_ctrl_if.sv
// Control/status bundle between the multicycle MIPS controller and its datapath.
// master = controller side (drives enables/selects), slave = datapath side.
interface mips_multicycle_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             iord;
  logic             memread;
  logic             memwrite;
  logic             irwrite;
  logic             regdst;
  logic             memtoreg;
  logic             regwrite;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       aluop;
  logic [1:0]       pcsrc;
  logic             pcwrite;
  logic             illegal_op;
  logic             bus_error;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, zero, mem_ready,
    output iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, aluop, pcsrc, pcwrite, illegal_op, bus_error, retired
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, aluop, pcsrc, pcwrite, illegal_op, bus_error, retired
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: one state per cycle, memory states stall on mem_ready
// and abort to FETCH with bus_error after TIMEOUT_CYCLES idle wait cycles (0 = never).
module mips_multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mips_multicycle_ctrl_if.master bus
);

  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] TO_VAL = WAIT_W'(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;
  localparam logic [3:0] S_JUMP   = 4'd12;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic [3:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              mem_state;
  logic              timeout;
  logic              op_legal;

  always_comb begin
    mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    timeout   = TO_EN && mem_state && !bus.mem_ready && (wait_q == TO_VAL);
    op_legal  = (bus.opcode == OP_R)   || (bus.opcode == OP_LW)   || (bus.opcode == OP_SW) ||
                (bus.opcode == OP_BEQ) || (bus.opcode == OP_ADDI) || (bus.opcode == OP_J);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
                else if (timeout)  state_d = S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
                else if (timeout)  state_d = S_FETCH;
      S_MEMWR:  if (bus.mem_ready || timeout) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  // An instruction retires only when it really completes; aborts and illegal ops do not count.
  always_comb begin
    retired_d = retired_q;
    if ((state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_BRANCH) ||
        (state_q == S_ADDIWB) || (state_q == S_JUMP) ||
        ((state_q == S_MEMWR) && bus.mem_ready))
      retired_d = retired_q + 1'b1;
  end

  // A timeout in FETCH re-enters FETCH without a state change, so it must clear explicitly.
  always_comb begin
    wait_d = wait_q;
    if ((state_d != state_q) || timeout)
      wait_d = '0;
    else if (mem_state && !bus.mem_ready)
      wait_d = wait_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    bus.iord       = 1'b0;
    bus.memread    = 1'b0;
    bus.memwrite   = 1'b0;
    bus.irwrite    = 1'b0;
    bus.regdst     = 1'b0;
    bus.memtoreg   = 1'b0;
    bus.regwrite   = 1'b0;
    bus.alusrca    = 1'b0;
    bus.alusrcb    = 2'b00;
    bus.aluop      = 2'b00;
    bus.pcsrc      = 2'b00;
    bus.pcwrite    = 1'b0;
    bus.illegal_op = 1'b0;
    bus.bus_error  = timeout;
    bus.retired    = retired_q;
    case (state_q)
      S_FETCH: begin
        bus.memread = 1'b1;
        bus.alusrcb = 2'b01;
        bus.irwrite = bus.mem_ready;
        bus.pcwrite = bus.mem_ready;
      end
      S_DECODE: begin
        bus.alusrcb    = 2'b11;
        bus.illegal_op = !op_legal;
      end
      S_MEMADR, S_ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      S_MEMRD: begin
        bus.iord    = 1'b1;
        bus.memread = 1'b1;
      end
      S_MEMWB: begin
        bus.memtoreg = 1'b1;
        bus.regwrite = 1'b1;
      end
      S_MEMWR: begin
        bus.iord     = 1'b1;
        bus.memwrite = 1'b1;
      end
      S_EXEC: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 2'b10;
      end
      S_ALUWB: begin
        bus.regdst   = 1'b1;
        bus.regwrite = 1'b1;
      end
      S_BRANCH: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 2'b01;
        bus.pcsrc   = 2'b01;
        bus.pcwrite = bus.zero;
      end
      S_ADDIWB: bus.regwrite = 1'b1;
      S_JUMP: begin
        bus.pcsrc   = 2'b10;
        bus.pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: each instruction is expanded into its expected per-cycle
// control words and retire points, then replayed against the DUT cycle by cycle.
module tb_mips_multicycle_ctrl;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_multicycle_ctrl_if #(.CNT_W(32)) bus ();
  mips_multicycle_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [16:0] cw;
    logic        rdy;
    logic        z;
    logic [5:0]  op;
    bit          ret;
  } cyc_t;

  cyc_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_ret = '0;
  logic [16:0] obs;

  function automatic logic [16:0] cw(input logic iord, memread, memwrite, irwrite, regdst,
                                     memtoreg, regwrite, alusrca, input logic [1:0] alusrcb,
                                     aluop, pcsrc, input logic pcwrite, illegal, buserr);
    return {iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
            alusrcb, aluop, pcsrc, pcwrite, illegal, buserr};
  endfunction

  //                     io mr mw ir rd mt rw as  srcb   aluop  pcsrc  pw il be
  logic [16:0] W_FETCH, W_FDONE, W_DECODE, W_MEMADR, W_MEMRD, W_MEMWB, W_MEMWR,
               W_EXEC, W_ALUWB, W_ADDIEX, W_ADDIWB, W_JUMP;

  function automatic logic [16:0] w_branch(input logic z);
    return cw(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, z, 0, 0);
  endfunction

  function automatic logic [16:0] sample();
    return {bus.iord, bus.memread, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg,
            bus.regwrite, bus.alusrca, bus.alusrcb, bus.aluop, bus.pcsrc, bus.pcwrite,
            bus.illegal_op, bus.bus_error};
  endfunction

  task automatic push(input logic [16:0] w, input logic r, input logic z,
                      input logic [5:0] op, input bit ret);
    cyc_t c;
    c.cw = w; c.rdy = r; c.z = z; c.op = op; c.ret = ret;
    q.push_back(c);
  endtask

  // Memory wait phase: ready arrives on wait cycle n; wait cycle TO without ready aborts.
  task automatic mem_phase(input logic [16:0] base, input logic [16:0] done, input int n,
                           input logic [5:0] op, input bit rnd_op, input bit ret, output bit ok);
    bit fin;
    logic [5:0] o;
    ok = 0;
    fin = 0;
    for (int k = 0; k <= TO && !fin; k++) begin
      o = rnd_op ? 6'($urandom) : op;
      if (k == n) begin
        push(done, 1'b1, 1'($urandom), o, ret);
        ok = 1;
        fin = 1;
      end else if (k == TO) begin
        push(base | 17'h1, 1'b0, 1'($urandom), o, 1'b0);
        fin = 1;
      end else begin
        push(base, 1'b0, 1'($urandom), o, 1'b0);
      end
    end
  endtask

  task automatic instr(input logic [5:0] op, input logic z, input int fw, input int mw);
    bit ok;
    mem_phase(W_FETCH, W_FDONE, fw, op, 1'b1, 1'b0, ok);
    if (!ok) return;
    case (op)
      6'b100011, 6'b101011: begin
        push(W_DECODE, 1'($urandom), 1'($urandom), op, 0);
        push(W_MEMADR, 1'($urandom), 1'($urandom), op, 0);
        if (op == 6'b100011) begin
          mem_phase(W_MEMRD, W_MEMRD, mw, op, 1'b0, 1'b0, ok);
          if (ok) push(W_MEMWB, 1'($urandom), 1'($urandom), op, 1);
        end else begin
          mem_phase(W_MEMWR, W_MEMWR, mw, op, 1'b0, 1'b1, ok);
        end
      end
      6'b000000: begin
        push(W_DECODE, 1'($urandom), 1'($urandom), op, 0);
        push(W_EXEC,   1'($urandom), 1'($urandom), op, 0);
        push(W_ALUWB,  1'($urandom), 1'($urandom), op, 1);
      end
      6'b000100: begin
        push(W_DECODE,    1'($urandom), 1'($urandom), op, 0);
        push(w_branch(z), 1'($urandom), z, op, 1);
      end
      6'b001000: begin
        push(W_DECODE, 1'($urandom), 1'($urandom), op, 0);
        push(W_ADDIEX, 1'($urandom), 1'($urandom), op, 0);
        push(W_ADDIWB, 1'($urandom), 1'($urandom), op, 1);
      end
      6'b000010: begin
        push(W_DECODE, 1'($urandom), 1'($urandom), op, 0);
        push(W_JUMP,   1'($urandom), 1'($urandom), op, 1);
      end
      default: push(W_DECODE | 17'h2, 1'($urandom), 1'($urandom), op, 0);
    endcase
  endtask

  task automatic check_cyc(input string tag, input logic [16:0] exp_cw);
    obs = sample();
    checks++;
    assert (obs === exp_cw) else begin
      errors++;
      $error("FAIL %s ctl observed=%h expected=%h", tag, obs, exp_cw);
    end
    checks++;
    assert (bus.retired === exp_ret) else begin
      errors++;
      $error("FAIL %s retired observed=%0d expected=%0d", tag, bus.retired, exp_ret);
    end
  endtask

  task automatic run_q(input string tag);
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(posedge clk);
      #1;
      bus.mem_ready = c.rdy;
      bus.zero      = c.z;
      bus.opcode    = c.op;
      @(negedge clk);
      check_cyc(tag, c.cw);
      if (c.ret) exp_ret = exp_ret + 1;
    end
  endtask

  function automatic logic [5:0] rand_illegal();
    logic [5:0] o;
    do o = 6'($urandom);
    while (o == 6'h23 || o == 6'h2b || o == 6'h00 || o == 6'h04 || o == 6'h08 || o == 6'h02);
    return o;
  endfunction

  initial begin
    cyc_t wb;
    logic [5:0] ops [6];
    int sel;
    ops = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h08, 6'h02};

    W_FETCH  = cw(0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0);
    W_FDONE  = cw(0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 0, 0);
    W_DECODE = cw(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0, 0);
    W_MEMADR = cw(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0, 0);
    W_MEMRD  = cw(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    W_MEMWB  = cw(0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    W_MEMWR  = cw(1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    W_EXEC   = cw(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0, 0);
    W_ALUWB  = cw(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    W_ADDIEX = cw(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0, 0);
    W_ADDIWB = cw(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    W_JUMP   = cw(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 1, 0, 0);

    bus.opcode = '0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_cyc("in_reset", '0);
    @(negedge clk) rst_n = 1'b1;
    #1 check_cyc("idle", '0);

    instr(6'b000000, 0, 0, 0);                run_q("rtype");
    instr(6'b100011, 0, 0, 0);                run_q("lw");
    instr(6'b101011, 0, 0, 0);                run_q("sw");
    instr(6'b000100, 1, 0, 0);                run_q("beq_taken");
    instr(6'b000100, 0, 0, 0);                run_q("beq_not");
    instr(6'b001000, 0, 3, 0);                run_q("fetch_wait3_addi");
    instr(6'b000010, 0, 0, 0);                run_q("jump");
    instr(6'b100011, 0, 2, 100);              run_q("lw_timeout");
    instr(6'b101011, 0, 0, TO);               run_q("sw_ready_at_limit");
    instr(6'b000000, 0, 100, 0);              run_q("fetch_timeout");
    instr(6'b111111, 0, 0, 0);                run_q("illegal_3f");
    instr(6'b100011, 0, 1, TO - 1);           run_q("lw_wait14");

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 6);
      instr((sel == 6) ? rand_illegal() : ops[sel], 1'($urandom),
            ($urandom_range(0, 9) == 0) ? 30 : $urandom_range(0, 4),
            ($urandom_range(0, 7) == 0) ? $urandom_range(14, 30) : $urandom_range(0, 4));
      run_q("random");
    end

    instr(6'b100011, 0, 0, 0);
    wb = q.pop_back();
    run_q("lw_pre_reset");
    @(posedge clk);
    #1;
    bus.mem_ready = wb.rdy; bus.zero = wb.z; bus.opcode = wb.op;
    @(negedge clk);
    check_cyc("memwb", wb.cw);
    rst_n = 1'b0;
    exp_ret = '0;
    #1 check_cyc("reset_in_memwb", '0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 check_cyc("idle_again", '0);

    instr(6'b000000, 0, 0, 0);
    push(W_FETCH, 1'b0, 1'($urandom), 6'($urandom), 0);
    run_q("rtype_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
